// File: rtl/cdc_handshake_rx.sv
// Receive-side endpoint of the 4-phase req/ack CDC handshake: synchronizes
// req_in, captures the source's held data word, offers it on valid/ready,
// and returns a registered ack to the source domain.
module cdc_handshake_rx #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_in,
  input  logic [WIDTH-1:0] data_in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] data_out,
  output logic             ack_out,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_sync;
  logic                   capture;

  // req_in synchronizer chain; only the last stage feeds logic
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], req_in};
    end
  end

  assign req_sync = sync_q[SYNC_STAGES-1];

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a req drop during HOLD is resolved by passing through ACK
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_sync) begin
          capture = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = ACK;
        end
      end
      ACK: begin
        if (!req_sync) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered outputs decoded from the next state so they track state_q exactly
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      ack_out   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      out_valid <= (state_d == HOLD);
      ack_out   <= (state_d == ACK);
      busy      <= (state_d != IDLE);
    end
  end

  // Data capture only on the IDLE->HOLD edge; held otherwise until next capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out <= '0;
    end else if (capture) begin
      data_out <= data_in;
    end
  end

endmodule

// File: tb/tb_cdc_handshake_rx.sv
// Directed bench for cdc_handshake_rx with a queue-based scoreboard.
module tb_cdc_handshake_rx;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             reset;
  logic             req_in;
  logic [WIDTH-1:0] data_in;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] data_out;
  logic             ack_out;
  logic             busy;

  int unsigned vectors;
  int unsigned miscompares;
  int unsigned accepted;
  logic [WIDTH-1:0] exp_q[$];

  cdc_handshake_rx #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_in    (req_in),
    .data_in   (data_in),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .data_out  (data_out),
    .ack_out   (ack_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted word must match the head of the expected queue
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL accept_unexpected: got 0x%0h expected none at %0t", data_out, $time);
      end else begin
        check("accept_data", 32'(data_out), 32'(exp_q.pop_front()));
      end
      accepted++;
    end
  end

  // Full 4-phase transfer with bounded waits on ack rise and fall
  task automatic xfer(input logic [WIDTH-1:0] d);
    int n;
    data_in = d;
    req_in  = 1'b1;
    exp_q.push_back(d);
    n = 0;
    while (!ack_out && n < 20) begin
      tick(1);
      n++;
    end
    check("b2b_ack_rise", 32'(ack_out), 32'd1);
    req_in = 1'b0;
    n = 0;
    while (ack_out && n < 20) begin
      tick(1);
      n++;
    end
    check("b2b_ack_fall", 32'(ack_out), 32'd0);
    check("b2b_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    accepted    = 0;
    reset       = 1'b0;
    req_in      = 1'b1;
    out_ready   = 1'b1;
    data_in     = 8'hFF;

    // Reset holds everything cleared even with req and ready asserted
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_ack", 32'(ack_out), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_data", 32'(data_out), 32'h00);
    end
    req_in = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(3);

    // Single transfer, ready already high
    data_in = 8'hA5;
    req_in  = 1'b1;
    exp_q.push_back(8'hA5);
    tick(2);
    check("single_valid_e2", 32'(out_valid), 32'd0);
    tick(1);
    check("single_valid_e3", 32'(out_valid), 32'd1);
    check("single_data", 32'(data_out), 32'hA5);
    check("single_busy", 32'(busy), 32'd1);
    tick(1);
    check("single_valid_pulse", 32'(out_valid), 32'd0);
    check("single_ack", 32'(ack_out), 32'd1);
    req_in = 1'b0;
    tick(2);
    check("single_ack_hold", 32'(ack_out), 32'd1);
    tick(1);
    check("single_ack_drop", 32'(ack_out), 32'd0);
    check("single_idle", 32'(busy), 32'd0);
    check("single_data_kept", 32'(data_out), 32'hA5);

    // Back-pressure: valid and data hold while ready is low
    out_ready = 1'b0;
    data_in   = 8'h3C;
    req_in    = 1'b1;
    exp_q.push_back(8'h3C);
    tick(3);
    check("bp_valid", 32'(out_valid), 32'd1);
    data_in = 8'h00; // captured word must not follow the bus while held
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("bp_valid_hold", 32'(out_valid), 32'd1);
      check("bp_data_hold", 32'(data_out), 32'h3C);
      check("bp_ack_low", 32'(ack_out), 32'd0);
    end
    out_ready = 1'b1;
    tick(1);
    check("bp_valid_drop", 32'(out_valid), 32'd0);
    check("bp_ack", 32'(ack_out), 32'd1);
    req_in = 1'b0;
    tick(3);
    check("bp_ack_drop", 32'(ack_out), 32'd0);

    // Back-to-back words through complete handshakes
    xfer(8'h01);
    xfer(8'h02);
    xfer(8'h03);
    check("b2b_accepted", accepted, 32'd5);

    // Req drops while HOLD: one accept, one ACK cycle, back to IDLE
    out_ready = 1'b0;
    data_in   = 8'h5A;
    req_in    = 1'b1;
    exp_q.push_back(8'h5A);
    tick(3);
    check("viol_valid", 32'(out_valid), 32'd1);
    req_in = 1'b0;
    tick(4);
    check("viol_still_hold", 32'(out_valid), 32'd1);
    check("viol_no_ack", 32'(ack_out), 32'd0);
    out_ready = 1'b1;
    tick(1);
    check("viol_ack", 32'(ack_out), 32'd1);
    check("viol_valid_drop", 32'(out_valid), 32'd0);
    tick(1);
    check("viol_ack_1cyc", 32'(ack_out), 32'd0);
    check("viol_idle", 32'(busy), 32'd0);

    // Reset during ACK clears asynchronously; release with req high recaptures
    data_in = 8'hC3;
    req_in  = 1'b1;
    exp_q.push_back(8'hC3);
    tick(4);
    check("mid_ack", 32'(ack_out), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_async_ack", 32'(ack_out), 32'd0);
    check("mid_async_busy", 32'(busy), 32'd0);
    check("mid_async_data", 32'(data_out), 32'h00);
    tick(1);
    reset = 1'b1;
    exp_q.push_back(8'hC3);
    tick(2);
    check("recap_valid_e2", 32'(out_valid), 32'd0);
    tick(1);
    check("recap_valid_e3", 32'(out_valid), 32'd1);
    check("recap_data", 32'(data_out), 32'hC3);
    tick(1);
    check("recap_ack", 32'(ack_out), 32'd1);
    req_in = 1'b0;
    tick(3);
    check("recap_ack_drop", 32'(ack_out), 32'd0);

    tick(2);
    check("total_accepted", accepted, 32'd8);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cdc_handshake_rx.md
# cdc_handshake_rx

Receive-side endpoint of the team's 4-phase req/ack CDC data-transfer handshake. It sits in the destination clock domain and synchronizes the incoming `req_in` through a flop chain. It captures the source's held data bus, presents it downstream on a valid/ready interface, and returns `ack_out` to the source domain. It is the counterpart of the source-side transmitter, which drives `req_in` and `data_in` and waits on the synchronized `ack_out`.

## Interface
- `WIDTH`, 8: data bus width.
- `SYNC_STAGES`, 2: flops in the `req_in` synchronizer chain; legal values are ≥ 2.

- `clk`  input  1  destination-domain clock; all state updates on rising edge.
- `reset`  input  1  asynchronous, active-low reset. Low clears all state immediately, independent of `clk`.
- `req_in`  input  1  request from source domain; asynchronous to `clk`.
- `data_in`  input  WIDTH  source data; held stable by the source while `req_in` is high.
- `out_ready`  input  1  downstream consumer can accept `data_out`.
- `out_valid`  output  1  `data_out` holds an unaccepted word.
- `data_out`  output  WIDTH  captured word; registered.
- `ack_out`  output  1  acknowledge to source domain; registered, glitch-free.
- `busy`  output  1  high whenever state ≠ IDLE.

## Operation
- Synchronizer: `req_in` passes through `SYNC_STAGES` flops. The last stage is `req_sync`. Only `req_sync` is used by logic; `req_in` is never used combinationally.
- `data_in` is never synchronized. It is sampled only in the cycle the FSM sees `req_sync`=1 in IDLE, by which point it has been stable for ≥ `SYNC_STAGES` cycles.
- FSM has 3 states:
  - IDLE: `out_valid`=0, `ack_out`=0. If `req_sync`=1: load `data_out` ← `data_in` and go to HOLD.
  - HOLD: `out_valid`=1, `ack_out`=0. If `out_ready`=1: transfer occurs and the state goes to ACK. `data_out` must not change in HOLD.
  - ACK: `out_valid`=0, `ack_out`=1. When `req_sync`=0: go to IDLE, and `ack_out` drops on that edge.
- All outputs are registered, decoded from state registers, with no combinational path from inputs.
- `data_out` retains the last captured word after transfer until the next capture.
- Protocol violation: if `req_in` falls during HOLD, the FSM stays in HOLD until accepted. It then passes through ACK for one cycle and returns to IDLE. No word is lost or duplicated.
- Since IDLE requires `req_sync`=1 and ACK requires `req_sync`=0, one 4-phase cycle yields exactly one word.

## Timing
- Reset values: all sync flops 0, state IDLE, `out_valid`=0, `ack_out`=0, `busy`=0, `data_out`=0.
- Let `req_in` rise before edge E1:
  - `req_sync`=1 after edge E(`SYNC_STAGES`).
  - Capture occurs at edge E(`SYNC_STAGES`+1), so `out_valid`=1 and `busy`=1 after that edge.
  - Latency from request to valid is `SYNC_STAGES`+1 edges, i.e. 3 at the default.
- With `out_ready` already high, acceptance occurs on the first edge with `out_valid`=1, and `ack_out`=1 after the next edge. `out_valid` is high for exactly 1 cycle.
- With `out_ready` low, `out_valid` holds indefinitely and `ack_out` stays 0. This back-pressures the source.
- Once `req_in` falls, `ack_out` falls `SYNC_STAGES`+1 edges later.
- Minimum full transfer at default, with zero source-side delay: 3 edges to valid, 1 to ack, then 3 after req falls.
- Reset asserted mid-transfer clears immediately. If `req_in` is still high after release, the word is recaptured. The source must tolerate this duplicate, as it is documented behaviour.
- `reset` deassertion must be synchronous to `clk` at system level. The block does not internally synchronize release.

## Test plan
- Reset: drive `reset`=0 with `req_in`=1 and `out_ready`=1 for 5 cycles. Required: `out_valid`=0, `ack_out`=0, `busy`=0, `data_out`=0x00 throughout.
- Single transfer: set `data_in`=0xA5, raise `req_in`, keep `out_ready`=1.
  - `out_valid` pulses 1 cycle exactly 3 edges later with `data_out`=0xA5.
  - `ack_out`=1 on the next cycle.
  - Drop `req_in`: `ack_out`=0 three edges later, `busy`=0.
- Back-pressure: use `data_in`=0x3C with `out_ready`=0 for 10 cycles.
  - `out_valid` stays 1 and `data_out`=0x3C stays stable.
  - `ack_out` stays 0.
  - Raise `out_ready`: one accept, then `ack_out`=1.
- Back-to-back: send 0x01, 0x02, 0x03 through a full 4-phase handshake each, with `out_ready`=1. Required: exactly 3 `out_valid` pulses carrying 0x01, 0x02, 0x03 in order, with no duplicates.
- Violation and mid-reset:
  - Drop `req_in` while in HOLD: word accepted once, ACK lasts 1 cycle, then IDLE.
  - Assert `reset` while in ACK: `ack_out`=0 asynchronously (before the next `clk` edge).
  - Release `reset` with `req_in`=1: recapture after 3 edges.
